// File: rtl/data_cache.sv
// data_cache: direct-mapped, write-back, write-allocate data cache between the
// CPU load/store port and a block-wide data memory.
// Optional feature macro: CACHE_STATS_EN (hit/miss counters; tied to 0 when undefined).
module data_cache #(
    parameter int WORD_SIZE   = 32,
    parameter int BLOCK_SIZE  = 16,
    parameter int LINES       = 8,
    parameter int MEM_LATENCY = 2
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            cpu_req,
    input  logic                            cpu_write,
    input  logic [WORD_SIZE-1:0]            cpu_addr,
    input  logic [WORD_SIZE-1:0]            cpu_wdata,
    output logic                            cpu_ack,
    output logic [WORD_SIZE-1:0]            cpu_rdata,
    output logic [WORD_SIZE-1:0]            mem_ptr_out,
    input  logic [BLOCK_SIZE*WORD_SIZE-1:0] mem_out_block,
    output logic [WORD_SIZE-1:0]            mem_ptr_in,
    output logic [BLOCK_SIZE*WORD_SIZE-1:0] mem_in_block,
    output logic                            mem_write_enable,
    output logic [31:0]                     hit_count,
    output logic [31:0]                     miss_count
);
    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = WORD_SIZE - 4 - IDX_W;
    localparam int BLK_W = BLOCK_SIZE * WORD_SIZE;
    // Last count value of a wait state; unused when MEM_LATENCY is 0 since
    // the wait states are bypassed entirely.
    localparam logic [3:0] WAIT_LAST = (MEM_LATENCY == 0) ? 4'd0 : 4'(MEM_LATENCY - 1);

    typedef enum logic [2:0] {IDLE, WB_WAIT, WB, FILL_WAIT, FILL, ACK} state_t;

    state_t state_q, state_d;
    logic [3:0] wait_cnt;

    // Line storage: valid/dirty are reset, tag/data are not.
    logic [LINES-1:0]     valid_q, dirty_q;
    logic [TAG_W-1:0]     tag_q  [LINES];
    logic [WORD_SIZE-1:0] data_q [LINES][BLOCK_SIZE];

    // Request captured at acceptance; everything after c0 works from these.
    logic                 req_write;
    logic [WORD_SIZE-1:0] req_addr, req_wdata;

    // Live address decode (used only in the acceptance cycle)
    logic [IDX_W-1:0] a_idx;
    logic [TAG_W-1:0] a_tag;
    logic [3:0]       a_off;
    assign a_idx = cpu_addr[4 +: IDX_W];
    assign a_tag = cpu_addr[WORD_SIZE-1 -: TAG_W];
    assign a_off = cpu_addr[3:0];

    // Captured address decode
    logic [IDX_W-1:0] r_idx;
    logic [TAG_W-1:0] r_tag;
    logic [3:0]       r_off;
    assign r_idx = req_addr[4 +: IDX_W];
    assign r_tag = req_addr[WORD_SIZE-1 -: TAG_W];
    assign r_off = req_addr[3:0];

    logic accept, hit, victim_dirty, wait_done;
    assign accept       = (state_q == IDLE) && cpu_req;
    assign hit          = valid_q[a_idx] && (tag_q[a_idx] == a_tag);
    assign victim_dirty = valid_q[a_idx] && dirty_q[a_idx];
    assign wait_done    = (wait_cnt == WAIT_LAST);

    assign cpu_ack          = (state_q == ACK);
    assign mem_write_enable = (state_q == WB);

    // Block (un)packing: word 0 sits in the MSBs.
    logic [WORD_SIZE-1:0] fill_w [BLOCK_SIZE];
    logic [BLK_W-1:0]     victim_blk;
    for (genvar k = 0; k < BLOCK_SIZE; k++) begin : g_blk
        assign fill_w[k] = mem_out_block[(BLOCK_SIZE-k)*WORD_SIZE-1 -: WORD_SIZE];
        assign victim_blk[(BLOCK_SIZE-k)*WORD_SIZE-1 -: WORD_SIZE] = data_q[a_idx][k];
    end

    // Next-state logic; zero latency bypasses both wait states.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (cpu_req) begin
                    if (hit)               state_d = ACK;
                    else if (victim_dirty) state_d = (MEM_LATENCY == 0) ? WB : WB_WAIT;
                    else                   state_d = (MEM_LATENCY == 0) ? FILL : FILL_WAIT;
                end
            end
            WB_WAIT:   if (wait_done) state_d = WB;
            WB:        state_d = (MEM_LATENCY == 0) ? FILL : FILL_WAIT;
            FILL_WAIT: if (wait_done) state_d = FILL;
            FILL:      state_d = ACK;
            ACK:       state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    // State register and memory wait counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            wait_cnt <= 4'd0;
        end else begin
            state_q <= state_d;
            if ((state_q == WB_WAIT || state_q == FILL_WAIT) && !wait_done)
                wait_cnt <= wait_cnt + 4'd1;
            else
                wait_cnt <= 4'd0;
        end
    end

    // Line status, request capture, load data and memory-side pointers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q      <= '0;
            dirty_q      <= '0;
            req_write    <= 1'b0;
            req_addr     <= '0;
            req_wdata    <= '0;
            cpu_rdata    <= '0;
            mem_ptr_out  <= '0;
            mem_ptr_in   <= '0;
            mem_in_block <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cpu_req) begin
                        req_write <= cpu_write;
                        req_addr  <= cpu_addr;
                        req_wdata <= cpu_wdata;
                        if (hit) begin
                            if (cpu_write) dirty_q[a_idx] <= 1'b1;
                            else           cpu_rdata      <= data_q[a_idx][a_off];
                        end else begin
                            mem_ptr_out <= {cpu_addr[WORD_SIZE-1:4], 4'b0};
                            // Victim is snapshotted now and held through WB.
                            if (victim_dirty) begin
                                mem_ptr_in   <= {tag_q[a_idx], a_idx, 4'b0};
                                mem_in_block <= victim_blk;
                            end
                        end
                    end
                end
                WB: dirty_q[r_idx] <= 1'b0;
                FILL: begin
                    valid_q[r_idx] <= 1'b1;
                    dirty_q[r_idx] <= req_write;
                    if (!req_write) cpu_rdata <= fill_w[r_off];
                end
                default: ;
            endcase
        end
    end

    // Tag/data arrays: store hits and line fills (store word merged in)
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (accept && hit && cpu_write)
                data_q[a_idx][a_off] <= cpu_wdata;
            if (state_q == FILL) begin
                tag_q[r_idx] <= r_tag;
                for (int k = 0; k < BLOCK_SIZE; k++)
                    data_q[r_idx][k] <= (req_write && r_off == 4'(k)) ? req_wdata : fill_w[k];
            end
        end
    end

`ifdef CACHE_STATS_EN
    logic [31:0] hit_q, miss_q;
    assign hit_count  = hit_q;
    assign miss_count = miss_q;

    // Hit/miss counters bumped at acceptance; wrap naturally
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hit_q  <= '0;
            miss_q <= '0;
        end else if (accept) begin
            if (hit) hit_q  <= hit_q + 32'd1;
            else     miss_q <= miss_q + 32'd1;
        end
    end
`else
    assign hit_count  = 32'd0;
    assign miss_count = 32'd0;
`endif

endmodule

// File: tb/tb_data_cache.sv
// tb_data_cache: directed bench with a response scoreboard for data_cache.
// Two instances: MEM_LATENCY=2 (main sequence) and MEM_LATENCY=0.
module tb_data_cache;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic cpu_write = 1'b0;
    logic [31:0] cpu_addr = '0, cpu_wdata = '0;
    logic cpu_req2 = 1'b0, cpu_req0 = 1'b0;

    logic ack2, ack0, we2, we0;
    logic [31:0] rdata2, rdata0, ptr_out2, ptr_out0, ptr_in2, ptr_in0;
    logic [31:0] hits2, miss2, hits0, miss0;
    logic [511:0] oblk2, oblk0, iblk2, iblk0;

    logic [31:0] mem2 [256];
    logic [31:0] mem0 [256];

    int total = 0;
    int bad = 0;

    typedef struct {
        logic [31:0] data;
        int          lat;
        bit          chkd;
    } exp_t;
    exp_t sb[$];

    // Results of the last request
    int          we_n, we_at;
    logic [31:0] we_ptr;
    logic [511:0] we_blk;
    logic [31:0] last_ptr_out;

    always #5 clk = ~clk;

    data_cache #(.WORD_SIZE(32), .BLOCK_SIZE(16), .LINES(8), .MEM_LATENCY(2)) dut2 (
        .clk(clk), .reset(reset), .cpu_req(cpu_req2), .cpu_write(cpu_write),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_ack(ack2), .cpu_rdata(rdata2),
        .mem_ptr_out(ptr_out2), .mem_out_block(oblk2), .mem_ptr_in(ptr_in2),
        .mem_in_block(iblk2), .mem_write_enable(we2), .hit_count(hits2), .miss_count(miss2));

    data_cache #(.WORD_SIZE(32), .BLOCK_SIZE(16), .LINES(8), .MEM_LATENCY(0)) dut0 (
        .clk(clk), .reset(reset), .cpu_req(cpu_req0), .cpu_write(cpu_write),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_ack(ack0), .cpu_rdata(rdata0),
        .mem_ptr_out(ptr_out0), .mem_out_block(oblk0), .mem_ptr_in(ptr_in0),
        .mem_in_block(iblk0), .mem_write_enable(we0), .hit_count(hits0), .miss_count(miss0));

    // Combinational block read, word 0 in the MSBs
    always_comb begin
        oblk2 = '0;
        oblk0 = '0;
        for (int k = 0; k < 16; k++) begin
            oblk2[(16-k)*32-1 -: 32] = mem2[{ptr_out2[7:4], 4'(k)}];
            oblk0[(16-k)*32-1 -: 32] = mem0[{ptr_out0[7:4], 4'(k)}];
        end
    end

    // Block write on the edge where write_enable is high
    always @(posedge clk) begin
        if (we2) for (int k = 0; k < 16; k++) mem2[{ptr_in2[7:4], 4'(k)}] <= iblk2[(16-k)*32-1 -: 32];
        if (we0) for (int k = 0; k < 16; k++) mem0[{ptr_in0[7:4], 4'(k)}] <= iblk0[(16-k)*32-1 -: 32];
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue one request on instance sel (1 = MEM_LATENCY 0), wait for ack,
    // then check it against the scoreboard entry pushed at issue time.
    task automatic run_req(input bit sel, input bit wr, input logic [31:0] addr,
                           input logic [31:0] wdata, input bit chkd,
                           input logic [31:0] expd, input int explat, input string tag);
        exp_t e;
        int cyc;
        bit got;
        logic [31:0] rd;
        sb.push_back('{data: expd, lat: explat, chkd: chkd});
        @(negedge clk);
        cpu_write = wr;
        cpu_addr  = addr;
        cpu_wdata = wdata;
        if (sel) cpu_req0 = 1'b1; else cpu_req2 = 1'b1;
        cyc = 0; got = 0; we_n = 0; we_at = -1; we_ptr = '0; we_blk = '0; rd = '0;
        for (int i = 0; i < 60 && !got; i++) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            if (sel ? we0 : we2) begin
                we_n++;
                we_at  = cyc;
                we_ptr = sel ? ptr_in0 : ptr_in2;
                we_blk = sel ? iblk0 : iblk2;
            end
            if (sel ? ack0 : ack2) begin
                got = 1;
                rd  = sel ? rdata0 : rdata2;
            end
        end
        last_ptr_out = sel ? ptr_out0 : ptr_out2;
        cpu_req0 = 1'b0;
        cpu_req2 = 1'b0;
        // Scramble inputs: the cache must not care after acceptance
        cpu_addr = 32'hFFFF_FFFF;
        cpu_wdata = 32'h5555_5555;
        e = sb.pop_front();
        chk({tag, " ack_seen"}, 64'(got), 64'd1);
        if (got) begin
            chk({tag, " latency"}, 64'(cyc), 64'(e.lat));
            if (e.chkd) chk({tag, " rdata"}, 64'(rd), 64'(e.data));
        end
        @(negedge clk);
        chk({tag, " ack_one_cycle"}, 64'(sel ? ack0 : ack2), 64'd0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem2[i] = 32'h1000_0000 + i;
            mem0[i] = 32'h1000_0000 + i;
        end
        mem2[8'h10] = 32'hAAAA_0001;
        mem0[8'h10] = 32'hAAAA_0001;

        repeat (3) @(negedge clk);
        // Reset state
        chk("rst ack", 64'(ack2), 64'd0);
        chk("rst rdata", 64'(rdata2), 64'd0);
        chk("rst ptr_out", 64'(ptr_out2), 64'd0);
        chk("rst ptr_in", 64'(ptr_in2), 64'd0);
        chk("rst we", 64'(we2), 64'd0);
        chk("rst in_block_zero", 64'(iblk2 == '0), 64'd1);
        chk("rst hit_count", 64'(hits2), 64'd0);
        chk("rst miss_count", 64'(miss2), 64'd0);
        reset = 1'b0;

        // 1. clean miss then hit
        run_req(0, 0, 32'h10, 32'h0, 1, 32'hAAAA_0001, 4, "t1 load miss");
        chk("t1 ptr_out", 64'(last_ptr_out), 64'h10);
        chk("t1 no_we", 64'(we_n), 64'd0);
        run_req(0, 0, 32'h10, 32'h0, 1, 32'hAAAA_0001, 1, "t1 load hit");

        // 2. store miss (write-allocate), then load hit
        run_req(0, 1, 32'h23, 32'hDEAD_BEEF, 0, 32'h0, 4, "t2 store miss");
        chk("t2 ptr_out", 64'(last_ptr_out), 64'h20);
        chk("t2 no_we", 64'(we_n), 64'd0);
        run_req(0, 0, 32'h23, 32'h0, 1, 32'hDEAD_BEEF, 1, "t2 load hit");

        // 3. conflicting load evicts dirty line 2
        run_req(0, 0, 32'hA3, 32'h0, 1, 32'h1000_00A3, 7, "t3 dirty miss");
        chk("t3 we_count", 64'(we_n), 64'd1);
        chk("t3 we_cycle", 64'(we_at), 64'd3);
        chk("t3 ptr_in", 64'(we_ptr), 64'h20);
        chk("t3 wb_word3", 64'(we_blk[415 -: 32]), 64'hDEAD_BEEF);
        chk("t3 wb_word0", 64'(we_blk[511 -: 32]), 64'h1000_0020);
        chk("t3 ptr_out", 64'(last_ptr_out), 64'hA0);
        chk("t3 mem_written", 64'(mem2[8'h23]), 64'hDEAD_BEEF);

        // 6. statistics over steps 1-3
`ifdef CACHE_STATS_EN
        chk("t6 hit_count", 64'(hits2), 64'd2);
        chk("t6 miss_count", 64'(miss2), 64'd3);
`else
        chk("t6 hit_count", 64'(hits2), 64'd0);
        chk("t6 miss_count", 64'(miss2), 64'd0);
`endif

        // 4. reset during FILL_WAIT of a load to 0x40
        @(negedge clk);
        cpu_write = 1'b0;
        cpu_addr  = 32'h40;
        cpu_req2  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("t4 fill_ptr", 64'(ptr_out2), 64'h40);
        reset = 1'b1;
        #1;
        chk("t4 rst_ptr_out", 64'(ptr_out2), 64'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t4 no_ack_in_reset", 64'(ack2), 64'd0);
        end
        cpu_req2 = 1'b0;
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t4 no_ack_after", 64'(ack2 | we2), 64'd0);
        end
        run_req(0, 0, 32'h10, 32'h0, 1, 32'hAAAA_0001, 4, "t4 reload miss");

        // 5. zero memory latency
        run_req(1, 0, 32'h10, 32'h0, 1, 32'hAAAA_0001, 2, "t5 clean miss");
        run_req(1, 1, 32'h25, 32'h1234_5678, 0, 32'h0, 2, "t5 store miss");
        run_req(1, 0, 32'hA5, 32'h0, 1, 32'h1000_00A5, 3, "t5 dirty miss");
        chk("t5 we_count", 64'(we_n), 64'd1);
        chk("t5 we_cycle", 64'(we_at), 64'd1);
        chk("t5 ptr_in", 64'(we_ptr), 64'h20);
        chk("t5 wb_word5", 64'(we_blk[351 -: 32]), 64'h1234_5678);
        run_req(1, 0, 32'h25, 32'h0, 1, 32'h1234_5678, 2, "t5 refetch");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
